// File: rtl/airpong_pkg.sv
// Shared AirPong definitions: HSV channel width, calibrator states and the
// fully-open threshold window used after reset.
package airpong_pkg;

  localparam int HSV_W = 8;

  // Fully-open window: every pixel passes until a calibration completes.
  localparam logic [HSV_W-1:0] WIN_LO_RST = 8'd0;
  localparam logic [HSV_W-1:0] WIN_HI_RST = 8'd255;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    ACCUM      = 3'd2,
    AVG        = 3'd3,
    UPDATE     = 3'd4
  } cal_state_t;

endpackage

// File: rtl/hsv_window_calc.sv
// One channel's threshold window: lo/hi = avg -/+ margin, either clamped to
// 0..255 or wrapped modulo 256 when wrap is high (hue is a circular quantity).
import airpong_pkg::*;

module hsv_window_calc (
  input  logic [HSV_W-1:0] avg,
  input  logic [HSV_W-1:0] margin,
  input  logic             wrap,
  output logic [HSV_W-1:0] lo,
  output logic [HSV_W-1:0] hi
);

  logic [HSV_W:0] lo_ext;
  logic [HSV_W:0] hi_ext;

  // Nine-bit difference/sum; bit 8 flags underflow (lo) or overflow (hi).
  always_comb begin
    lo_ext = {1'b0, avg} - {1'b0, margin};
    hi_ext = {1'b0, avg} + {1'b0, margin};
    if (wrap) begin
      lo = lo_ext[HSV_W-1:0];
      hi = hi_ext[HSV_W-1:0];
    end else begin
      lo = lo_ext[HSV_W] ? WIN_LO_RST : lo_ext[HSV_W-1:0];
      hi = hi_ext[HSV_W] ? WIN_HI_RST : hi_ext[HSV_W-1:0];
    end
  end

endmodule

// File: rtl/hsv_threshold_calibrator.sv
// Averages the selected pixel's H/S/V over 2^LOG2_FRAMES frames after a start
// pulse and publishes avg +/- margin windows for the colour-tracking mask.
// Optional build macro: AIRPONG_HUE_WRAP_EN (hue window wraps modulo 256).
import airpong_pkg::*;

module hsv_threshold_calibrator #(
  parameter int LOG2_FRAMES = 4,
  parameter int H_MARGIN    = 10,
  parameter int S_MARGIN    = 40,
  parameter int V_MARGIN    = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             frame_tick,
  input  logic [HSV_W-1:0] h_sel,
  input  logic [HSV_W-1:0] s_sel,
  input  logic [HSV_W-1:0] v_sel,
  output logic [HSV_W-1:0] h_lo,
  output logic [HSV_W-1:0] h_hi,
  output logic [HSV_W-1:0] s_lo,
  output logic [HSV_W-1:0] s_hi,
  output logic [HSV_W-1:0] v_lo,
  output logic [HSV_W-1:0] v_hi,
  output logic             busy,
  output logic             done,
  output logic             valid
);

  localparam int ACC_W = HSV_W + LOG2_FRAMES;
  localparam int CNT_W = LOG2_FRAMES + 1;
  // Counter value seen on the tick that takes the final sample.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_FRAMES) - 1);
  localparam logic [HSV_W-1:0] H_M = HSV_W'(H_MARGIN);
  localparam logic [HSV_W-1:0] S_M = HSV_W'(S_MARGIN);
  localparam logic [HSV_W-1:0] V_M = HSV_W'(V_MARGIN);

`ifdef AIRPONG_HUE_WRAP_EN
  localparam logic HUE_WRAP = 1'b1;
`else
  localparam logic HUE_WRAP = 1'b0;
`endif

  cal_state_t       state;
  cal_state_t       next_state;
  logic [ACC_W-1:0] h_acc;
  logic [ACC_W-1:0] s_acc;
  logic [ACC_W-1:0] v_acc;
  logic [CNT_W-1:0] count;
  logic [HSV_W-1:0] h_avg;
  logic [HSV_W-1:0] s_avg;
  logic [HSV_W-1:0] v_avg;
  logic [HSV_W-1:0] h_lo_calc;
  logic [HSV_W-1:0] h_hi_calc;
  logic [HSV_W-1:0] s_lo_calc;
  logic [HSV_W-1:0] s_hi_calc;
  logic [HSV_W-1:0] v_lo_calc;
  logic [HSV_W-1:0] v_hi_calc;

  // Truncating division by the frame count; the upper bits are always zero.
  assign h_avg = HSV_W'(h_acc >> LOG2_FRAMES);
  assign s_avg = HSV_W'(s_acc >> LOG2_FRAMES);
  assign v_avg = HSV_W'(v_acc >> LOG2_FRAMES);

  hsv_window_calc u_h_win (.avg(h_avg), .margin(H_M), .wrap(HUE_WRAP), .lo(h_lo_calc), .hi(h_hi_calc));
  hsv_window_calc u_s_win (.avg(s_avg), .margin(S_M), .wrap(1'b0),     .lo(s_lo_calc), .hi(s_hi_calc));
  hsv_window_calc u_v_win (.avg(v_avg), .margin(V_M), .wrap(1'b0),     .lo(v_lo_calc), .hi(v_hi_calc));

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = WAIT_FRAME;
        else       next_state = IDLE;
      end
      WAIT_FRAME: begin
        if (frame_tick) next_state = ACCUM;
        else            next_state = WAIT_FRAME;
      end
      ACCUM: begin
        if (frame_tick && (count == LAST_CNT)) next_state = AVG;
        else                                   next_state = ACCUM;
      end
      AVG:     next_state = UPDATE;
      UPDATE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, accumulators and registered outputs. The averaged windows are
  // captured on the AVG edge so done and the new thresholds appear together
  // two cycles after the last sampled tick, during the UPDATE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      h_acc <= '0;
      s_acc <= '0;
      v_acc <= '0;
      count <= '0;
      h_lo  <= WIN_LO_RST;
      h_hi  <= WIN_HI_RST;
      s_lo  <= WIN_LO_RST;
      s_hi  <= WIN_HI_RST;
      v_lo  <= WIN_LO_RST;
      v_hi  <= WIN_HI_RST;
      busy  <= 1'b0;
      done  <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (state == AVG);
      case (state)
        IDLE: begin
          if (start) begin
            h_acc <= '0;
            s_acc <= '0;
            v_acc <= '0;
            count <= '0;
          end
        end
        ACCUM: begin
          if (frame_tick) begin
            h_acc <= h_acc + ACC_W'(h_sel);
            s_acc <= s_acc + ACC_W'(s_sel);
            v_acc <= v_acc + ACC_W'(v_sel);
            count <= count + CNT_W'(1);
          end
        end
        AVG: begin
          h_lo  <= h_lo_calc;
          h_hi  <= h_hi_calc;
          s_lo  <= s_lo_calc;
          s_hi  <= s_hi_calc;
          v_lo  <= v_lo_calc;
          v_hi  <= v_hi_calc;
          valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/hsv_threshold_calibrator.md
Name: hsv_threshold_calibrator

Overview:
- Downstream consumer of the selected-pixel HSV triple (h_sel/s_sel/v_sel) produced by the pixel-picker stage.
- On a user start pulse, samples that triple once per video frame for 2^LOG2_FRAMES frames and averages each channel.
- Emits per-channel lo/hi threshold windows (average ± margin) that feed the colour-tracking mask stage of AirPong.

Parameters:
- LOG2_FRAMES, 4, log2 of the number of frames averaged; legal range 1..6.
- H_MARGIN, 10, hue half-window (8-bit).
- S_MARGIN, 40, saturation half-window (8-bit).
- V_MARGIN, 40, value half-window (8-bit).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle calibration request (debounced button pulse).
- frame_tick  in  1  one-cycle pulse per frame, at vsync start.
- h_sel  in  8  selected-pixel hue.
- s_sel  in  8  selected-pixel saturation.
- v_sel  in  8  selected-pixel value.
- h_lo, h_hi  out  8 each  hue window bounds.
- s_lo, s_hi  out  8 each  saturation window bounds.
- v_lo, v_hi  out  8 each  value window bounds.
- busy  out  1  high while calibrating.
- done  out  1  one-cycle pulse when new thresholds are written.
- valid  out  1  high once any calibration has completed; held until reset.

Behaviour:
- Clocking and reset: single clock domain. Synchronous, active-high reset. All outputs are registered.
- Reset values: all *_lo = 0; all *_hi = 255; busy = 0; done = 0; valid = 0; state = IDLE; accumulators and sample counter = 0.
- IDLE: start=1 → WAIT_FRAME. Accumulators and counter clear in the same edge. frame_tick is ignored in IDLE, including when it coincides with start.
- WAIT_FRAME: discards the partial frame in progress. The first frame_tick → ACCUM, with no sample taken.
- ACCUM:
  - Each frame_tick adds h_sel, s_sel and v_sel into three accumulators, each 8+LOG2_FRAMES bits wide (overflow impossible), and increments the counter.
  - On the tick that takes sample number 2^LOG2_FRAMES → AVG.
- AVG: one cycle. Each average = accumulator >> LOG2_FRAMES (truncating). Registered, then → UPDATE.
- UPDATE: one cycle.
  - lo = avg − margin, hi = avg + margin, computed in 9-bit signed/extended arithmetic.
  - Saturate to 0..255 (hue wrap rules below).
  - Outputs are written, done=1, valid=1 → IDLE.
- Latency: new thresholds and done are visible in the second cycle after the cycle in which the final sampled frame_tick is high.
- busy = 1 in WAIT_FRAME, ACCUM, AVG and UPDATE.
- start while busy: ignored; calibration continues unchanged.
- Between calibrations, thresholds hold their last written values.
- reset mid-calibration: returns to IDLE with reset values. Previous thresholds are lost.
- Back-to-back: start in the cycle after done begins a new calibration normally.

Optional Feature:
- Macro: AIRPONG_HUE_WRAP_EN.
- Defined: hue window is computed modulo 256.
  - h_lo = (avg − H_MARGIN) mod 256; h_hi = (avg + H_MARGIN) mod 256.
  - h_lo > h_hi signals a wrapped window to the mask stage.
  - S and V still saturate.
- Undefined: hue saturates to 0..255 like S and V.

Decomposition:
- Shared package airpong_pkg:
  - HSV_W = 8.
  - Calibrator state enum: IDLE, WAIT_FRAME, ACCUM, AVG, UPDATE.
  - Default reset window constants (0 / 255).
- Sub-module hsv_window_calc:
  - Combinational: one channel's avg, margin and a wrap-enable input → lo/hi.
  - Instantiated three times; wrap tied high only for hue under AIRPONG_HUE_WRAP_EN.

Test Plan:
- LOG2_FRAMES=2, constant h/s/v=100/200/50, default margins, start then 5 ticks → h 90..110, s 160..240, v 10..90; done pulses once; valid=1; busy low after.
- Varying h=10,11,12,13 across the 4 sampled ticks (first tick after start discarded) → average 11 (truncated); h_lo=1, h_hi=21.
- Saturation: s=230, v=20 → s_lo 190, s_hi 255, v_lo 0, v_hi 60.
- h=5:
  - With AIRPONG_HUE_WRAP_EN → h_lo 251, h_hi 15.
  - Without → h_lo 0, h_hi 15.
- start pulsed again mid-ACCUM → ignored; sample count and result unchanged. start and frame_tick in the same IDLE cycle → that tick is not sampled.
- reset asserted during ACCUM after a prior calibration → next cycle all lo=0, hi=255, valid=0, busy=0; a fresh calibration then completes correctly.
